// File: rtl/rs_symbol_packer.sv
// ============================================================================
// Module : rs_symbol_packer
// Brief  : Packs a synchronised serial bit stream into SYM_W-bit symbols,
//          frames them into MSG_SYMS-symbol messages (sop/eop) and buffers
//          them in a FWFT FIFO behind a valid/ready handshake.
//          Optional macro PACKER_STATS_EN adds a saturating drop_count port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_symbol_packer #(
  parameter int SYM_W      = 8,
  parameter int MSG_SYMS   = 223,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          bit_clk,
  input  logic                          bit_in,
  input  logic                          enable,
  output logic [SYM_W-1:0]              sym_data,
  output logic                          sym_sop,
  output logic                          sym_eop,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef PACKER_STATS_EN
  output logic [15:0]                   drop_count,
`endif
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam int CW = $clog2(MSG_SYMS);
  localparam int WW = SYM_W + 2;

  logic          bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic          bin_s1_q, bin_s2_q;
  logic          bit_edge, take_bit, sym_done;
  logic [SYM_W-1:0] shift_q, shift_d, shift_next;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [WW-1:0] push_word, head_word;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty, push_ok, pop, drop;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      bin_s1_q  <= 1'b0;
      bin_s2_q  <= 1'b0;
    end else begin
      bclk_s1_q <= bit_clk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      bin_s1_q  <= bit_in;
      bin_s2_q  <= bin_s1_q;
    end
  end

  assign bit_edge = bclk_s2_q & ~bclk_s3_q;
  assign take_bit = bit_edge & enable;
  assign sym_done = take_bit & (bit_cnt_q == BW'(SYM_W - 1));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_q[SYM_W-2:0], bin_s2_q};
    end else begin : g_lsb_first
      assign shift_next = {bin_s2_q, shift_q[SYM_W-1:1]};
    end
  endgenerate

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sym_cnt_d = sym_cnt_q;
    if (!enable) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      sym_cnt_d = '0;
    end else if (take_bit) begin
      shift_d   = shift_next;
      bit_cnt_d = sym_done ? '0 : bit_cnt_q + BW'(1);
      // Framing advances even for dropped symbols to stay aligned to the stream
      if (sym_done)
        sym_cnt_d = (sym_cnt_q == CW'(MSG_SYMS - 1)) ? '0 : sym_cnt_q + CW'(1);
    end
  end

  assign push_word = {(sym_cnt_q == '0), (sym_cnt_q == CW'(MSG_SYMS - 1)), shift_next};

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = ~fifo_empty & sym_ready;
  assign push_ok    = sym_done & (~fifo_full | pop);
  assign drop       = sym_done & ~push_ok;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk_in) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= push_word;
  end

  assign head_word  = mem_q[rd_ptr_q];
  assign sym_valid  = ~fifo_empty;
  assign sym_data   = sym_valid ? head_word[SYM_W-1:0] : '0;
  assign sym_eop    = sym_valid & head_word[SYM_W];
  assign sym_sop    = sym_valid & head_word[SYM_W+1];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

`ifdef PACKER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

`default_nettype wire
